// File: rtl/mdu_controller.sv
// mdu_controller: sequences one RV32M request through the combinational MDU.
// Holds operands on the MDU for a fixed window and captures d3 at the end.
// Divide corner cases are resolved locally without using the MDU.
// Ports: clk, rst_n (async, active low); req_* request handshake with
// operands, funct3 and tag; flush kills the in-flight op; mdu_s1/s2/funct3
// go to the MDU, mdu_d3 comes back; res_* result handshake with tag;
// stall holds the pipeline.
// Optional macro MDU_RESULT_CACHE_EN adds a one-entry result cache.
module mdu_controller #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3,
    parameter int TAG_WIDTH    = 5,
    parameter int MUL_LAT      = 2,
    parameter int DIV_LAT      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   req_s1,
    input  logic [DATA_WIDTH-1:0]   req_s2,
    input  logic [FUNCT3_WIDTH-1:0] req_funct3,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    input  logic                    flush,
    output logic [DATA_WIDTH-1:0]   mdu_s1,
    output logic [DATA_WIDTH-1:0]   mdu_s2,
    output logic [FUNCT3_WIDTH-1:0] mdu_funct3,
    input  logic [DATA_WIDTH-1:0]   mdu_d3,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic [TAG_WIDTH-1:0]    res_tag,
    output logic                    stall
);

    typedef enum logic [1:0] {IDLE, BUSY, SPECIAL, DONE} state_t;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_M1 = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV_LAT - 1);
    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   spec_q;
    logic [DATA_WIDTH-1:0]   spec_val;
    logic [DATA_WIDTH-1:0]   cached;
    logic                    accept;
    logic                    is_div, is_rem, is_signed;
    logic                    div_zero, div_ovf, corner, hit;

    assign accept = req_valid & req_ready & ~flush;

    // funct3[2] selects divide, [1] selects remainder, [0] unsigned
    assign is_div    = req_funct3[2];
    assign is_rem    = req_funct3[1];
    assign is_signed = ~req_funct3[0];
    assign div_zero  = is_div & (req_s2 == '0);
    assign div_ovf   = is_div & is_signed & (req_s1 == INT_MIN) & (req_s2 == '1);
    assign corner    = div_zero | div_ovf;

`ifdef MDU_RESULT_CACHE_EN
    logic                    cache_valid;
    logic [DATA_WIDTH-1:0]   c_s1, c_s2, c_res;
    logic [FUNCT3_WIDTH-1:0] c_f3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            c_s1        <= '0;
            c_s2        <= '0;
            c_f3        <= '0;
            c_res       <= '0;
        end else if (flush) begin
            cache_valid <= 1'b0;
        end else if (state == BUSY && cnt == '0) begin
            cache_valid <= 1'b1;
            c_s1        <= mdu_s1;
            c_s2        <= mdu_s2;
            c_f3        <= mdu_funct3;
            c_res       <= mdu_d3;
        end
    end

    assign hit    = cache_valid & (req_s1 == c_s1) & (req_s2 == c_s2)
                  & (req_funct3 == c_f3);
    assign cached = c_res;
`else
    assign hit    = 1'b0;
    assign cached = '0;
`endif

    // Corner rules take precedence over a cache hit
    always_comb begin
        spec_val = cached;
        if (div_zero)
            spec_val = is_rem ? req_s1 : '1;
        else if (div_ovf)
            spec_val = is_rem ? '0 : INT_MIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept) state_nx = (corner | hit) ? SPECIAL : BUSY;
                BUSY:    if (cnt == '0) state_nx = DONE;
                SPECIAL: state_nx = DONE;
                DONE:    if (res_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = (state == IDLE);
        res_valid = (state == DONE);
        stall     = (req_valid & ~req_ready) | (state == BUSY);
    end

    // MDU input registers only load for ops that really use the MDU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_s1     <= '0;
            mdu_s2     <= '0;
            mdu_funct3 <= '0;
            cnt        <= '0;
            spec_q     <= '0;
            res_data   <= '0;
            res_tag    <= '0;
        end else begin
            if (accept) begin
                res_tag <= req_tag;
                spec_q  <= spec_val;
                if (!(corner | hit)) begin
                    mdu_s1     <= req_s1;
                    mdu_s2     <= req_s2;
                    mdu_funct3 <= req_funct3;
                    cnt        <= req_funct3[2] ? DIV_M1 : MUL_M1;
                end
            end
            if (state == BUSY && !flush) begin
                if (cnt == '0) res_data <= mdu_d3;
                else           cnt      <= cnt - 1'b1;
            end
            if (state == SPECIAL && !flush)
                res_data <= spec_q;
        end
    end

endmodule

// File: tb/tb_mdu_controller.sv
// tb_mdu_controller: directed scoreboard bench for mdu_controller.
// A behavioural RV32M model stands in for the combinational MDU.
module tb_mdu_controller;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_s1;
    logic [31:0] req_s2;
    logic [2:0]  req_funct3;
    logic [4:0]  req_tag;
    logic        flush;
    logic [31:0] mdu_s1;
    logic [31:0] mdu_s2;
    logic [2:0]  mdu_funct3;
    logic [31:0] mdu_d3;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_tag;
    logic        stall;

    mdu_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_s1     (req_s1),
        .req_s2     (req_s2),
        .req_funct3 (req_funct3),
        .req_tag    (req_tag),
        .flush      (flush),
        .mdu_s1     (mdu_s1),
        .mdu_s2     (mdu_s2),
        .mdu_funct3 (mdu_funct3),
        .mdu_d3     (mdu_d3),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .stall      (stall)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  tag;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic pv = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mdu_f(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [2:0]  f);
        logic signed [63:0] ss, su;
        logic [63:0]        uu;
        logic [31:0]        r;
        ss = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        su = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
        uu = {32'b0, a} * {32'b0, b};
        r = 32'h0;
        case (f)
            3'd0: r = uu[31:0];
            3'd1: r = ss[63:32];
            3'd2: r = su[63:32];
            3'd3: r = uu[63:32];
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a :
                      32'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 :
                      32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    always_comb mdu_d3 = mdu_f(mdu_s1, mdu_s2, mdu_funct3);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever a new result appears
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && !pv) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", {31'b0, res_valid}, 32'h0);
                end else begin
                    cur = q.pop_front();
                    chk("res_data", res_data, cur.d);
                    chk("res_tag", {27'b0, res_tag}, {27'b0, cur.tag});
                    chk("latency", 32'(cyc - cur.t0), 32'(cur.lat));
                end
            end else if (res_valid) begin
                chk("hold_data", res_data, cur.d);
                chk("hold_tag", {27'b0, res_tag}, {27'b0, cur.tag});
            end
            pv = res_valid;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [4:0] t,
                         input logic [31:0] e, input int lat);
        exp_t        x;
        logic [31:0] sa, sb;
        int          n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'h0, 32'h1);
        sa = mdu_s1;
        sb = mdu_s2;
        req_valid  = 1'b1;
        req_s1     = a;
        req_s2     = b;
        req_funct3 = f;
        req_tag    = t;
        x.d = e;
        x.tag = t;
        x.lat = lat;
        x.t0 = cyc;
        q.push_back(x);
        @(posedge clk);
        #1 req_valid = 1'b0;
        // Unused MDU path (corner or cache hit) must leave MDU inputs alone
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk);
            chk("busy_ready", {31'b0, req_ready}, 32'h0);
            chk("mdu_s1_hold", mdu_s1, (lat > 2) ? a : sa);
            chk("mdu_s2_hold", mdu_s2, (lat > 2) ? b : sb);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q.size() != 0 || !req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_s1 = '0;
        req_s2 = '0;
        req_funct3 = '0;
        req_tag = '0;
        flush = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_res_tag", {27'b0, res_tag}, 32'h0);
        chk("rst_mdu_s1", mdu_s1, 32'h0);
        chk("rst_mdu_s2", mdu_s2, 32'h0);
        chk("rst_mdu_f3", {29'b0, mdu_funct3}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        rst_n = 1'b1;

        issue(32'd6, 32'd7, 3'd0, 5'd3, 32'd42, 3);
        issue(32'd20, 32'd4, 3'd4, 5'd5, 32'd5, 5);
        issue(32'd20, 32'd6, 3'd6, 5'd6, 32'd2, 5);
        issue(32'd20, 32'd0, 3'd5, 5'd7, 32'hFFFF_FFFF, 2);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 5'd8, 32'h0, 2);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 5'd9, 32'h8000_0000, 2);
        issue(32'd77, 32'd0, 3'd7, 5'd10, 32'd77, 2);
        issue(32'd9, 32'd0, 3'd4, 5'd11, 32'hFFFF_FFFF, 2);
        wait_done();

        // Backpressure on MULH
        res_ready = 1'b0;
        issue(32'd200000, 32'd60000, 3'd1, 5'd12, 32'h2, 3);
        repeat (4) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, res_valid}, 32'h1);
            chk("bp_stall", {31'b0, stall}, 32'h0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("hs_ready_after", {31'b0, req_ready}, 32'h1);
        chk("hs_valid_drop", {31'b0, res_valid}, 32'h0);
        issue(32'd3, 32'd5, 3'd0, 5'd13, 32'd15, 3);
        wait_done();

        // Flush in the second BUSY cycle of a DIV
        @(negedge clk);
        req_valid = 1'b1;
        req_s1 = 32'd100;
        req_s2 = 32'd7;
        req_funct3 = 3'd4;
        req_tag = 5'd14;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", {31'b0, req_ready}, 32'h1);
        chk("flush_no_valid", {31'b0, res_valid}, 32'h0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("flush_discard", 32'(seen), 32'h0);

        // Request together with flush in IDLE is dropped
        req_valid = 1'b1;
        flush = 1'b1;
        req_s1 = 32'd9;
        req_s2 = 32'd9;
        req_funct3 = 3'd0;
        @(posedge clk);
        #1 begin
            req_valid = 1'b0;
            flush = 1'b0;
        end
        @(negedge clk);
        chk("flush_req_ready", {31'b0, req_ready}, 32'h1);
        chk("flush_req_mdu", mdu_s1, 32'd100);

        // Reset in the middle of a DIV
        @(negedge clk);
        req_valid = 1'b1;
        req_s1 = 32'd50;
        req_s2 = 32'd5;
        req_funct3 = 3'd4;
        req_tag = 5'd15;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ready", {31'b0, req_ready}, 32'h1);
        chk("mrst_valid", {31'b0, res_valid}, 32'h0);
        chk("mrst_data", res_data, 32'h0);
        chk("mrst_tag", {27'b0, res_tag}, 32'h0);
        chk("mrst_mdu_s1", mdu_s1, 32'h0);
        chk("mrst_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MDU_RESULT_CACHE_EN
        issue(32'd6, 32'd7, 3'd0, 5'd1, 32'd42, 3);
        issue(32'd6, 32'd7, 3'd0, 5'd2, 32'd42, 2);
        wait_done();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        issue(32'd6, 32'd7, 3'd0, 5'd3, 32'd42, 3);
`else
        issue(32'd6, 32'd7, 3'd0, 5'd1, 32'd42, 3);
        issue(32'd6, 32'd7, 3'd0, 5'd2, 32'd42, 3);
`endif
        wait_done();
        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
